fp_div: RTL and testbench



---
 rtl/fp_div_if.sv | 30 +++
 rtl/fp_div.sv | 173 +++++++++++++++++
 tb/tb_fp_div.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fp_div_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : fp_div_if
// Brief  : Operand/result bus and start/done handshake for the fp_div divider.
// Rev    : 1.0  initial release
// ============================================================================
interface fp_div_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic [31:0] R;
    logic        done;
    logic        busy;
    logic        div_by_zero;
    logic        invalid;
    logic        overflow;
    logic        underflow;

    modport master (
        output A, B, start,
        input  R, done, busy, div_by_zero, invalid, overflow, underflow
    );

    modport slave (
        input  A, B, start,
        output R, done, busy, div_by_zero, invalid, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fp_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : fp_div
// Brief  : IEEE-754 single-precision divider, sequential restoring mantissa
//          division, RNE rounding, denormals flushed. Optional macro
//          FP_DIV_EARLY_EXIT_EN stops iterating once the remainder is zero.
// Rev    : 1.0  initial release
// ============================================================================
module fp_div #(
    parameter int QBITS = 27
) (
    input  wire      clk,
    input  wire      rst,
    fp_div_if.slave  bus
);
    localparam int CW = $clog2(QBITS);
    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DIV   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state, w_next_state;
    logic [31:0]       r_a, r_b;
    logic              r_sign;
    logic [9:0]        r_exp;
    logic [24:0]       r_rem;
    logic [23:0]       r_div;
    logic [QBITS-1:0]  r_q;
    logic [CW-1:0]     r_cnt;
    logic [23:0]       r_mant;
    logic              r_guard, r_sticky;
    logic [31:0]       r_r;
    logic              r_done, r_busy;
    logic              r_dbz, r_inv, r_ovf, r_unf;

    logic              w_accept;
    logic              w_a_max, w_b_max, w_a_zero, w_b_zero, w_special;
    logic              w_ge, w_early, w_last;
    logic [24:0]       w_rem_sub;
    logic [QBITS-1:0]  w_q_next;
    logic              w_inc;
    logic [24:0]       w_sum;
    logic [23:0]       w_mant_r;
    logic [9:0]        w_exp_r;

    assign bus.R           = r_r;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
    assign bus.div_by_zero = r_dbz;
    assign bus.invalid     = r_inv;
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_unf;

    // DONE spends one cycle raising done before a new start can be taken
    assign w_accept  = bus.start && !r_busy && (r_state == S_IDLE || r_state == S_DONE);
    assign w_a_max   = &r_a[30:23];
    assign w_b_max   = &r_b[30:23];
    assign w_a_zero  = (r_a[30:23] == 8'd0);
    assign w_b_zero  = (r_b[30:23] == 8'd0);
    assign w_special = w_a_max || w_b_max || w_a_zero || w_b_zero;

    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
    assign w_q_next  = {r_q[QBITS-2:0], w_ge};
    assign w_last    = (r_cnt == CW'(QBITS - 1));
`ifdef FP_DIV_EARLY_EXIT_EN
    assign w_early   = (w_rem_sub == 25'd0);
`else
    assign w_early   = 1'b0;
`endif

    assign w_inc    = r_guard && (r_sticky || r_mant[0]);
    assign w_sum    = {1'b0, r_mant} + {24'd0, w_inc};
    assign w_mant_r = w_sum[24] ? w_sum[24:1] : w_sum[23:0];
    assign w_exp_r  = r_exp + {9'd0, w_sum[24]};

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_accept) w_next_state = S_LOAD;
            S_LOAD:         w_next_state = w_special ? S_DONE : S_DIV;
            S_DIV:          if (w_last || w_early) w_next_state = S_NORM;
            S_NORM:         w_next_state = S_ROUND;
            S_ROUND:        w_next_state = S_DONE;
            default:        w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a <= '0;  r_b <= '0;  r_sign <= 1'b0;  r_exp <= '0;
            r_rem <= '0;  r_div <= '0;  r_q <= '0;  r_cnt <= '0;
            r_mant <= '0;  r_guard <= 1'b0;  r_sticky <= 1'b0;
            r_r <= '0;  r_done <= 1'b0;  r_busy <= 1'b0;
            r_dbz <= 1'b0;  r_inv <= 1'b0;  r_ovf <= 1'b0;  r_unf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a <= bus.A;  r_b <= bus.B;
                        r_done <= 1'b0;  r_busy <= 1'b1;
                        r_dbz <= 1'b0;  r_inv <= 1'b0;  r_ovf <= 1'b0;  r_unf <= 1'b0;
                    end else if (r_state == S_DONE) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_sign <= r_a[31] ^ r_b[31];
                    r_exp  <= {2'b00, r_a[30:23]} - {2'b00, r_b[30:23]} + 10'd127;
                    r_rem  <= {2'b01, r_a[22:0]};
                    r_div  <= {1'b1, r_b[22:0]};
                    r_q    <= '0;
                    r_cnt  <= '0;
                    if (w_a_max || w_b_max || (w_a_zero && w_b_zero)) begin
                        r_r   <= C_QNAN;
                        r_inv <= 1'b1;
                    end else if (w_b_zero) begin
                        r_r   <= {r_a[31] ^ r_b[31], 8'hFF, 23'd0};
                        r_dbz <= 1'b1;
                    end else if (w_a_zero) begin
                        r_r   <= {r_a[31] ^ r_b[31], 31'd0};
                    end
                end
                S_DIV: begin
                    // remainder stays below the divisor, so the shift fits 25 bits
                    r_rem <= w_rem_sub << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_early) r_q <= w_q_next << (QBITS - 1 - int'(r_cnt));
                    else         r_q <= w_q_next;
                end
                S_NORM: begin
                    if (r_q[QBITS-1]) begin
                        r_mant   <= r_q[QBITS-1 -: 24];
                        r_guard  <= r_q[QBITS-25];
                        r_sticky <= (|r_q[QBITS-26:0]) || (r_rem != 25'd0);
                    end else begin
                        r_mant   <= r_q[QBITS-2 -: 24];
                        r_guard  <= r_q[QBITS-26];
                        r_sticky <= (|r_q[QBITS-27:0]) || (r_rem != 25'd0);
                        r_exp    <= r_exp - 10'd1;
                    end
                end
                S_ROUND: begin
                    r_exp <= w_exp_r;
                    if ($signed(w_exp_r) >= 10'sd255) begin
                        r_r   <= {r_sign, 8'hFF, 23'd0};
                        r_ovf <= 1'b1;
                    end else if ($signed(w_exp_r) <= 10'sd0) begin
                        r_r   <= {r_sign, 31'd0};
                        r_unf <= 1'b1;
                    end else begin
                        r_r   <= {r_sign, w_exp_r[7:0], w_mant_r[22:0]};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_fp_div
// Brief  : Directed self-checking bench for fp_div (results, flags, latency,
//          handshake and reset behaviour).
// Rev    : 1.0  initial release
// ============================================================================
module tb_fp_div;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat;
    logic [3:0] flags;

    fp_div_if bus();

    fp_div #(.QBITS(27)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign flags = {bus.div_by_zero, bus.invalid, bus.overflow, bus.underflow};

    // Issue one operation; lat = edges from the accept edge until done is seen
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int l);
        @(negedge clk);
        bus.A = a;  bus.B = b;  bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A = 32'hDEAD_BEEF;  bus.B = 32'h1234_5678;
        l = 0;
        while (bus.done !== 1'b1 && l < 200) begin
            @(posedge clk); #1; l++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;  bus.start = 1'b0;  bus.A = '0;  bus.B = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.R !== 32'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset: R=%h done=%b busy=%b flags=%b, expected R=0 done=0 busy=0 flags=0000",
                     bus.R, bus.done, bus.busy, flags);
        end
        rst = 1'b1;
    endtask

    task automatic test_normal();
        logic [31:0] va [3] = '{32'h40C0_0000, 32'h3F80_0000, 32'hC040_0000};
        logic [31:0] vb [3] = '{32'h4000_0000, 32'h4040_0000, 32'h3FC0_0000};
        logic [31:0] vr [3] = '{32'h4040_0000, 32'h3EAA_AAAB, 32'hC000_0000};
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], lat);
            n_tests++;
            if (bus.R !== vr[i] || flags !== 4'b0000 || lat !== 31) begin
                n_fail++;
                $display("FAIL normal[%0d]: R=%h flags=%b lat=%0d, expected R=%h flags=0000 lat=31",
                         i, bus.R, flags, lat, vr[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] va [5] = '{32'hBF80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h8000_0000};
        logic [31:0] vb [5] = '{32'h0000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h4000_0000};
        logic [31:0] vr [5] = '{32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h8000_0000};
        logic [3:0]  vf [5] = '{4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], lat);
            n_tests++;
            if (bus.R !== vr[i] || flags !== vf[i] || lat !== 2) begin
                n_fail++;
                $display("FAIL special[%0d]: R=%h flags=%b lat=%0d, expected R=%h flags=%b lat=2",
                         i, bus.R, flags, lat, vr[i], vf[i]);
            end
        end
    endtask

    task automatic test_range();
        run_op(32'h7F00_0000, 32'h3E80_0000, lat);
        n_tests++;
        if (bus.R !== 32'h7F80_0000 || flags !== 4'b0010 || lat !== 31) begin
            n_fail++;
            $display("FAIL overflow: R=%h flags=%b lat=%0d, expected R=7f800000 flags=0010 lat=31",
                     bus.R, flags, lat);
        end
        run_op(32'h0080_0000, 32'h4000_0000, lat);
        n_tests++;
        if (bus.R !== 32'h0000_0000 || flags !== 4'b0001 || lat !== 31) begin
            n_fail++;
            $display("FAIL underflow: R=%h flags=%b lat=%0d, expected R=00000000 flags=0001 lat=31",
                     bus.R, flags, lat);
        end
    endtask

    task automatic test_start_ignored();
        @(negedge clk);
        bus.A = 32'h40C0_0000;  bus.B = 32'h4000_0000;  bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (4) begin @(posedge clk); #1; lat++; end
        bus.A = 32'h3F80_0000;  bus.B = 32'h4040_0000;  bus.start = 1'b1;
        @(posedge clk); #1; lat++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if (bus.R !== 32'h4040_0000 || lat !== 31) begin
            n_fail++;
            $display("FAIL start_ignored: R=%h lat=%0d, expected R=40400000 lat=31", bus.R, lat);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.A = 32'h40C0_0000;  bus.B = 32'h4000_0000;  bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bus.R !== 32'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: R=%h done=%b busy=%b flags=%b, expected R=0 done=0 busy=0 flags=0000",
                     bus.R, bus.done, bus.busy, flags);
        end
        rst = 1'b1;
        run_op(32'h3F80_0000, 32'h4040_0000, lat);
        n_tests++;
        if (bus.R !== 32'h3EAA_AAAB || flags !== 4'b0000 || lat !== 31) begin
            n_fail++;
            $display("FAIL after_reset: R=%h flags=%b lat=%0d, expected R=3eaaaaab flags=0000 lat=31",
                     bus.R, flags, lat);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.A = 32'h40C0_0000;  bus.B = 32'h4000_0000;  bus.start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if (bus.R !== 32'h4040_0000 || lat !== 31) begin
            n_fail++;
            $display("FAIL b2b_first: R=%h lat=%0d, expected R=40400000 lat=31", bus.R, lat);
        end
        bus.A = 32'h3F80_0000;  bus.B = 32'h4040_0000;
        @(posedge clk); #1;
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: done=%b busy=%b, expected done=0 busy=1", bus.done, bus.busy);
        end
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if (bus.R !== 32'h3EAA_AAAB || lat !== 31) begin
            n_fail++;
            $display("FAIL b2b_second: R=%h lat=%0d, expected R=3eaaaaab lat=31", bus.R, lat);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
